// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor with a direct-mapped BTB: predicts next_pc in IF, trained from EX.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module gshare_branch_predictor #(
   parameter int XLEN     = 32,
   parameter int IDX_BITS = 5,
   parameter int GHR_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [XLEN-1:0]     if_pc,
   output logic                pred_taken,
   output logic [XLEN-1:0]     pred_target,
   output logic [IDX_BITS-1:0] pred_idx,
   input  logic                upd_valid,
   input  logic                upd_is_cond,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic [XLEN-1:0]     upd_pc,
   input  logic                upd_taken,
   input  logic [XLEN-1:0]     upd_target,
   input  logic                upd_mispredict,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispred
);

   localparam int TAG_BITS = XLEN - IDX_BITS - 2;
   localparam int ENTRIES  = 1 << IDX_BITS;

   logic [GHR_BITS-1:0] r_ghr;
   logic [1:0]          r_bht        [ENTRIES];
   logic [ENTRIES-1:0]  r_btb_valid;
   logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
   logic [XLEN-1:0]     r_btb_target [ENTRIES];

   logic [IDX_BITS-1:0] w_ghr_ext;
   logic [IDX_BITS-1:0] w_idx;
   logic [TAG_BITS-1:0] w_tag;
   logic                w_hit;
   logic                w_taken;
   logic [XLEN-1:0]     w_seq_pc;
   logic                w_btb_we;
   logic                w_unused_bits;

   function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && ctr != 2'b11)
         nxt = ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
         nxt = ctr - 2'b01;
      return nxt;
   endfunction

   // History is shorter than (or equal to) the index, so it is zero-extended into the XOR.
   always_comb begin
      w_ghr_ext                 = '0;
      w_ghr_ext[GHR_BITS-1:0]   = r_ghr;
   end

   assign w_idx       = if_pc[IDX_BITS+1:2] ^ w_ghr_ext;
   assign w_tag       = if_pc[XLEN-1:IDX_BITS+2];
   assign w_hit       = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
   assign w_taken     = w_hit && r_bht[w_idx][1];
   assign w_seq_pc    = if_pc + XLEN'(4);

   assign pred_idx    = w_idx;
   assign pred_taken  = w_taken;
   assign pred_target = w_taken ? r_btb_target[w_idx] : w_seq_pc;

   assign w_btb_we    = upd_valid && (!upd_is_cond || upd_taken);

   // Control state: history, counters and valid bits are cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ghr       <= '0;
         r_btb_valid <= '0;
         for (int i = 0; i < ENTRIES; i++)
            r_bht[i] <= 2'b01;
      end else if (upd_valid) begin
         if (upd_is_cond) begin
            r_bht[upd_idx] <= f_ctr_next(r_bht[upd_idx], upd_taken);
            r_ghr          <= {r_ghr[GHR_BITS-2:0], upd_taken};
         end else begin
            r_bht[upd_idx] <= 2'b11;
         end
         if (w_btb_we)
            r_btb_valid[upd_idx] <= 1'b1;
      end
   end

   // Tag/target payload needs no reset: an entry is only consulted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (w_btb_we) begin
         r_btb_tag[upd_idx]    <= upd_pc[XLEN-1:IDX_BITS+2];
         r_btb_target[upd_idx] <= upd_target;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispred;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else if (upd_valid) begin
         if (r_stat_branches != 32'hFFFF_FFFF)
            r_stat_branches <= r_stat_branches + 32'd1;
         if (upd_mispredict && r_stat_mispred != 32'hFFFF_FFFF)
            r_stat_mispred <= r_stat_mispred + 32'd1;
      end
   end

   assign stat_branches = r_stat_branches;
   assign stat_mispred  = r_stat_mispred;
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

   // Low PC bits are word-offset bits covered by the index; mispredict only feeds the stats.
   assign w_unused_bits = ^{if_pc[1:0], upd_pc[IDX_BITS+1:0], upd_mispredict};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor; expected stats follow BP_STATS_EN.
module tb_gshare_branch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [4:0]  pred_idx;
   logic        upd_valid;
   logic        upd_is_cond;
   logic [4:0]  upd_idx;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef BP_STATS_EN
   localparam logic [31:0] EXP_BR = 32'd3;
   localparam logic [31:0] EXP_MP = 32'd1;
`else
   localparam logic [31:0] EXP_BR = 32'd0;
   localparam logic [31:0] EXP_MP = 32'd0;
`endif

   gshare_branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .pred_idx       (pred_idx),
      .upd_valid      (upd_valid),
      .upd_is_cond    (upd_is_cond),
      .upd_idx        (upd_idx),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_upd(input logic cond, input logic tk, input logic mis,
                          input logic [4:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
      upd_is_cond    = cond;
      upd_taken      = tk;
      upd_mispredict = mis;
      upd_idx        = idx;
      upd_pc         = pc;
      upd_target     = tgt;
   endtask

   task automatic train(input logic cond, input logic tk, input logic mis,
                        input logic [4:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
      @(negedge clk);
      set_upd(cond, tk, mis, idx, pc, tgt);
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic expect_pred(input string tag, input logic [31:0] pc,
                              input logic tk, input logic [31:0] tgt, input logic [4:0] idx);
      if_pc = pc;
      #1;
      chk({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, tk});
      chk({tag, "_target"}, pred_target, tgt);
      chk({tag, "_idx"},    {27'd0, pred_idx}, {27'd0, idx});
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      if_pc     = 32'h40;
      upd_valid = 1'b0;
      set_upd(1'b0, 1'b1, 1'b0, 5'h10, 32'h40, 32'h100);

      // Reset held across edges with a training strobe present: nothing may be learnt.
      upd_valid = 1'b1;
      repeat (2) @(negedge clk);
      expect_pred("rst_hold", 32'h40, 1'b0, 32'h44, 5'h10);
      chk("rst_stat_br", stat_branches, 32'd0);
      chk("rst_stat_mp", stat_mispred, 32'd0);
      upd_valid = 1'b0;
      reset     = 1'b1;
      expect_pred("rst_after", 32'h40, 1'b0, 32'h44, 5'h10);

      // Jump training at index 0x10.
      train(1'b0, 1'b1, 1'b0, 5'h10, 32'h40, 32'h100);
      expect_pred("jal_hit",   32'h40,  1'b1, 32'h100, 5'h10);
      expect_pred("jal_alias", 32'h840, 1'b0, 32'h844, 5'h10);

      // Counter saturation at idx 0; ghr shifts so the probe PC keeps index 0 with tag 1.
      repeat (4) train(1'b1, 1'b1, 1'b0, 5'h00, 32'h80, 32'h200);
      expect_pred("sat_t4",  32'hBC, 1'b1, 32'h200, 5'h00);
      train(1'b1, 1'b0, 1'b0, 5'h00, 32'h80, 32'h200);
      expect_pred("sat_nt1", 32'hF8, 1'b1, 32'h200, 5'h00);
      train(1'b1, 1'b0, 1'b0, 5'h00, 32'h80, 32'h200);
      expect_pred("sat_nt2", 32'hF0, 1'b0, 32'hF4, 5'h00);

      // History: T,T,NT from a cleared ghr gives 0b00110.
      reset_pulse();
      train(1'b1, 1'b1, 1'b0, 5'h05, 32'h300, 32'h400);
      train(1'b1, 1'b1, 1'b0, 5'h05, 32'h300, 32'h400);
      train(1'b1, 1'b0, 1'b0, 5'h05, 32'h300, 32'h400);
      expect_pred("ghr_idx",  32'h0,   1'b0, 32'h4,   5'h06);
      expect_pred("ghr_hit",  32'h30C, 1'b1, 32'h400, 5'h05);

      // Same-cycle train and fetch of entry 5: old target now, new after the edge.
      @(negedge clk);
      if_pc = 32'h30C;
      set_upd(1'b0, 1'b1, 1'b0, 5'h05, 32'h30C, 32'h500);
      upd_valid = 1'b1;
      #1;
      chk("sim_old_target", pred_target, 32'h400);
      @(negedge clk);
      upd_valid = 1'b0;
      expect_pred("sim_new", 32'h30C, 1'b1, 32'h500, 5'h05);

      // Statistics and asynchronous mid-cycle reset.
      reset_pulse();
      train(1'b0, 1'b1, 1'b1, 5'h10, 32'h40, 32'h100);
      train(1'b0, 1'b1, 1'b0, 5'h11, 32'h44, 32'h120);
      train(1'b0, 1'b1, 1'b0, 5'h12, 32'h48, 32'h140);
      chk("stat_br", stat_branches, EXP_BR);
      chk("stat_mp", stat_mispred,  EXP_MP);
      expect_pred("pre_async", 32'h44, 1'b1, 32'h120, 5'h11);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_taken",  {31'd0, pred_taken}, 32'd0);
      chk("async_target", pred_target, 32'h48);
      chk("async_br",     stat_branches, 32'd0);
      chk("async_mp",     stat_mispred,  32'd0);
      #1;
      reset = 1'b1;
      @(negedge clk);
      expect_pred("post_async", 32'h40, 1'b0, 32'h44, 5'h10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
